fifo_burst_reader: RTL and testbench

- Read-side controller for sync_FIFO: the only consumer of the FIFO's r_en/data_out port.
- Waits until FIFO occupancy reaches a programmable burst length, or a flush is requested, then pops the burst with back-to-back r_en.
- Absorbs the FIFO's 1-cycle registered read latency in a 2-entry output buffer.
- Presents words downstream on a valid/ready stream with an end-of-burst marker.

---
 rtl/fifo_burst_reader.sv | 134 +++++++++++++
 tb/tb_fifo_burst_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for a registered-output sync FIFO: waits for a full burst (or flush),
// pops it back-to-back, and re-times the words through a 2-entry skid buffer onto a valid/ready stream.
module fifo_burst_reader #(
    parameter int FIFO_data_size = 3,
    parameter int FIFO_addr_size = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [FIFO_addr_size:0]   burst_len,
    input  logic                      flush,
    output logic                      fifo_r_en,
    input  logic [FIFO_data_size-1:0] fifo_data,
    input  logic                      fifo_empty,
    input  logic [FIFO_addr_size:0]   fifo_count,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FIFO_data_size-1:0] out_data,
    output logic                      out_last,
    output logic                      busy
);

    localparam int CW = FIFO_addr_size + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1 << FIFO_addr_size);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             remaining_q, remaining_d;
    logic                      pending_q, pending_d;
    logic                      pending_last_q, pending_last_d;
    logic [FIFO_data_size-1:0] buf_data_q [2];
    logic [FIFO_data_size-1:0] buf_data_d [2];
    logic                      buf_last_q [2];
    logic                      buf_last_d [2];
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                occ_q, occ_d;

    logic [CW-1:0]             eff_len;
    logic [2:0]                inflight;
    logic                      pop;
    logic                      issue;

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = buf_data_q[rd_ptr_q];
    assign out_last  = out_valid && buf_last_q[rd_ptr_q];
    assign busy      = (state_q == BURST) || pending_q || out_valid;
    assign pop       = out_valid && out_ready;

    // Words already buffered or in flight, minus the one leaving this cycle, must leave a free slot.
    assign inflight  = {1'b0, occ_q} + {2'b0, pending_q};
    assign issue     = rst && (state_q == BURST) && (remaining_q != '0) && !fifo_empty
                       && (inflight <= (3'd1 + {2'b0, pop}));
    assign fifo_r_en = issue;

    always_comb begin
        eff_len = burst_len;
        if (burst_len == '0) begin
            eff_len = CW'(1);
        end else if (burst_len > DEPTH) begin
            eff_len = DEPTH;
        end
    end

    always_comb begin
        state_d        = state_q;
        remaining_d    = remaining_q;
        pending_d      = issue;
        pending_last_d = issue && (remaining_q == CW'(1));
        buf_data_d     = buf_data_q;
        buf_last_d     = buf_last_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        occ_d          = occ_q + {1'b0, pending_q} - {1'b0, pop};

        case (state_q)
            IDLE: begin
                if (fifo_count >= eff_len) begin
                    state_d     = BURST;
                    remaining_d = eff_len;
                end else if (flush && !fifo_empty) begin
                    state_d     = BURST;
                    remaining_d = fifo_count;
                end
            end
            BURST: begin
                if (issue) begin
                    remaining_d = remaining_q - CW'(1);
                    if (remaining_q == CW'(1)) begin
                        state_d = IDLE;
                    end
                end else if (remaining_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The FIFO's registered output is valid exactly one cycle after the pop.
        if (pending_q) begin
            buf_data_d[wr_ptr_q] = fifo_data;
            buf_last_d[wr_ptr_q] = pending_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            remaining_q    <= '0;
            pending_q      <= 1'b0;
            pending_last_q <= 1'b0;
            buf_data_q     <= '{default: '0};
            buf_last_q     <= '{default: 1'b0};
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            occ_q          <= 2'd0;
        end else begin
            state_q        <= state_d;
            remaining_q    <= remaining_d;
            pending_q      <= pending_d;
            pending_last_q <= pending_last_d;
            buf_data_q     <= buf_data_d;
            buf_last_q     <= buf_last_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            occ_q          <= occ_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a behavioural 4-deep registered-output FIFO feeds the reader, and a
// scoreboard of {last, data} pushed at write time is compared against every accepted output word.
module tb_fifo_burst_reader;

    localparam int DW = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] burst_len;
    logic          flush;
    logic          fifo_r_en;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;

    logic          w_en;
    logic          w_last;
    logic [DW-1:0] w_data;
    logic [DW-1:0] mem [4];
    logic [1:0]    wp, rp;
    logic [CW-1:0] cnt;
    logic          do_w, do_r;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ren_cnt, vld_cnt, ren_first, ren_last, vld_first;
    int n;
    logic [DW:0] sb [$];

    always #5 clk = ~clk;

    fifo_burst_reader #(.FIFO_data_size(DW), .FIFO_addr_size(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .burst_len  (burst_len),
        .flush      (flush),
        .fifo_r_en  (fifo_r_en),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_count (fifo_count),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy)
    );

    assign fifo_empty = (cnt == 3'd0);
    assign fifo_count = cnt;
    assign do_w       = w_en && (cnt != 3'd4);
    assign do_r       = fifo_r_en && (cnt != 3'd0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wp        <= 2'd0;
            rp        <= 2'd0;
            cnt       <= 3'd0;
            fifo_data <= '0;
        end else begin
            if (do_w) begin
                mem[wp] <= w_data;
                wp      <= wp + 2'd1;
            end
            if (do_r) begin
                fifo_data <= mem[rp];
                rp        <= rp + 2'd1;
            end
            cnt <= cnt + {2'b0, do_w} - {2'b0, do_r};
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic mark();
        ren_cnt   = 0;
        vld_cnt   = 0;
        ren_first = -1;
        ren_last  = -1;
        vld_first = -1;
    endtask

    // One clock: sample at the falling edge, then return just after the rising edge.
    task automatic tick();
        logic [DW:0] e;
        @(negedge clk);
        cyc++;
        if (fifo_r_en) begin
            if (ren_first < 0) ren_first = cyc;
            ren_last = cyc;
            ren_cnt++;
        end
        if (out_valid) begin
            if (vld_first < 0) vld_first = cyc;
            vld_cnt++;
        end
        if (do_w && rst) sb.push_back({w_last, w_data});
        if (out_valid && out_ready && rst) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_data", 32'(out_data), 32'(e[DW-1:0]));
                chk("out_last", 32'(out_last), 32'(e[DW]));
                $display("word data=%0d last=%0d exp_data=%0d exp_last=%0d",
                         out_data, out_last, e[DW-1:0], e[DW]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [DW-1:0] d, input logic l);
        w_en   = 1'b1;
        w_data = d;
        w_last = l;
        tick();
        w_en   = 1'b0;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        burst_len = 3'd4;
        flush     = 1'b0;
        out_ready = 1'b1;
        w_en      = 1'b0;
        w_data    = '0;
        w_last    = 1'b0;
        n         = 0;
        mark();
        idle(2);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_r_en", 32'(fifo_r_en), 0);
        rst = 1'b1;

        // Full-length burst of 4
        mark();
        write(3'd1, 1'b0);
        write(3'd2, 1'b0);
        write(3'd3, 1'b0);
        idle(3);
        chk("t1_no_ren_below_len", ren_cnt, 0);
        write(3'd4, 1'b1);
        idle(10);
        chk("t1_ren_count", ren_cnt, 4);
        chk("t1_ren_consecutive", ren_last - ren_first, 3);
        chk("t1_latency", vld_first - ren_first, 2);
        chk("t1_valid_cycles", vld_cnt, 4);
        chk("t1_sb_drained", sb.size(), 0);
        chk("t1_busy_low", 32'(busy), 0);

        // Flush of a single word
        burst_len = 3'd2;
        mark();
        write(3'd5, 1'b1);
        idle(3);
        chk("t2_no_ren_before_flush", ren_cnt, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle(6);
        chk("t2_ren_count", ren_cnt, 1);
        chk("t2_sb_drained", sb.size(), 0);
        chk("t2_fifo_empty", 32'(fifo_count), 0);
        chk("t2_busy_low", 32'(busy), 0);

        // Back-pressure: only two words fit before the stall
        burst_len = 3'd4;
        out_ready = 1'b0;
        mark();
        write(3'd6, 1'b0);
        write(3'd7, 1'b0);
        write(3'd0, 1'b0);
        write(3'd1, 1'b1);
        idle(8);
        chk("t3_ren_stalled", ren_cnt, 2);
        chk("t3_valid_held", 32'(out_valid), 1);
        chk("t3_head_word", 32'(out_data), 6);
        idle(3);
        chk("t3_head_frozen", 32'(out_data), 6);
        chk("t3_ren_still_stalled", ren_cnt, 2);
        out_ready = 1'b1;
        idle(10);
        chk("t3_ren_total", ren_cnt, 4);
        chk("t3_sb_drained", sb.size(), 0);
        chk("t3_busy_low", 32'(busy), 0);

        // burst_len 0 behaves as 1
        burst_len = 3'd0;
        mark();
        write(3'd2, 1'b1);
        idle(6);
        chk("t4_ren_count", ren_cnt, 1);
        chk("t4_sb_drained", sb.size(), 0);

        // Reset after two pops of a four-word burst
        burst_len = 3'd4;
        mark();
        write(3'd3, 1'b0);
        write(3'd4, 1'b0);
        write(3'd5, 1'b0);
        write(3'd6, 1'b1);
        for (int i = 0; i < 20 && ren_cnt < 2; i++) tick();
        chk("t5_two_pops", ren_cnt, 2);
        rst       = 1'b0;
        out_ready = 1'b0;
        tick();
        chk("t5_rst_valid", 32'(out_valid), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_r_en", 32'(fifo_r_en), 0);
        sb.delete();
        rst = 1'b1;
        tick();
        chk("t5_post_rst_r_en", 32'(fifo_r_en), 0);
        mark();
        out_ready = 1'b1;
        write(3'd7, 1'b0);
        write(3'd0, 1'b0);
        write(3'd1, 1'b0);
        idle(4);
        chk("t5_no_ren_below_len", ren_cnt, 0);
        chk("t5_no_output", vld_cnt, 0);
        write(3'd2, 1'b1);
        idle(10);
        chk("t5_ren_count", ren_cnt, 4);
        chk("t5_sb_drained", sb.size(), 0);

        // Streaming 2-word bursts with random back-pressure
        burst_len = 3'd2;
        mark();
        for (int i = 0; i < 400 && n < 60; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (cnt < 3'd4) begin
                w_en   = 1'b1;
                w_data = DW'(n);
                w_last = n[0];
                n++;
            end else begin
                w_en = 1'b0;
            end
            tick();
        end
        w_en      = 1'b0;
        out_ready = 1'b1;
        idle(20);
        chk("t6_words_written", n, 60);
        chk("t6_ren_count", ren_cnt, 60);
        chk("t6_sb_drained", sb.size(), 0);
        chk("t6_busy_low", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
